// File: rtl/if_id_stage_pkg.sv
// Shared IF/ID pipeline definitions: default widths, the NOP bubble word, skid-buffer state encoding.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package if_id_stage_pkg;

   localparam int INS_W_DEF = 32;
   localparam int PC_W_DEF  = 32;

   // MIPS "sll $0,$0,0": an all-zero word decodes as a harmless no-op.
   localparam logic [31:0] NOP_INS_DEF = 32'h0000_0000;

   // Occupancy of the two-entry skid buffer.
   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_TWO   = 2'd2
   } skid_state_e;

endpackage

// File: rtl/if_id_stage_pipe_skid_buf.sv
// Generic two-entry valid/ready skid buffer; strict FIFO order, the skid entry is never overtaken.
// Latency: 1 cycle from accept to out_valid when empty.
// Backpressure: in_ready is a flop, low only while both entries are held; flush empties it.
module pipe_skid_buf
   import if_id_stage_pkg::*;
#(
   parameter int W = 64
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         flush,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [W-1:0] in_data,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [W-1:0] out_data
);

   skid_state_e  state_q, state_d;
   logic [W-1:0] main_q, main_d;
   logic [W-1:0] skid_q, skid_d;
   logic         rdy_q, rdy_d;
   logic         accept;
   logic         drain;

   assign in_ready  = rdy_q;
   assign out_valid = (state_q != ST_EMPTY);
   assign out_data  = main_q;
   assign accept    = in_valid && rdy_q;
   assign drain     = out_valid && out_ready;

   // Next-state and entry movement; flush overrides everything and drops the incoming word.
   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               state_d = ST_ONE;
               main_d  = in_data;
            end
         end
         ST_ONE: begin
            if (accept && !drain) begin
               state_d = ST_TWO;
               skid_d  = in_data;
            end else if (accept && drain) begin
               main_d  = in_data;
            end else if (drain) begin
               state_d = ST_EMPTY;
            end
         end
         ST_TWO: begin
            if (drain) begin
               state_d = ST_ONE;
               main_d  = skid_q;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      if (flush) begin
         state_d = ST_EMPTY;
      end
      // Ready is precomputed from the next state so it leaves a flop.
      rdy_d = (state_d != ST_TWO);
   end

   // State, ready flag and both payload entries.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_EMPTY;
         rdy_q   <= 1'b1;
         main_q  <= '0;
         skid_q  <= '0;
      end else begin
         state_q <= state_d;
         rdy_q   <= rdy_d;
         main_q  <= main_d;
         skid_q  <= skid_d;
      end
   end

endmodule

// File: rtl/if_id_stage.sv
// IF/ID pipeline register carrying {instruction, PC+4}, NOP bubble when empty, saturating stall counter.
// Latency: 1 cycle from accept to out_valid when the stage is empty.
// Backpressure: SKID=1 two-entry buffer with registered in_ready; SKID=0 single register, in_ready = !out_valid || out_ready.
module if_id_stage
   import if_id_stage_pkg::*;
#(
   parameter int               INS_W   = INS_W_DEF,
   parameter int               PC_W    = PC_W_DEF,
   parameter logic [INS_W-1:0] NOP_INS = INS_W'(NOP_INS_DEF),
   parameter bit               SKID    = 1'b1,
   parameter int               CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [INS_W-1:0] ins_in,
   input  logic [PC_W-1:0]  pc_plus4_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [INS_W-1:0] ins_out,
   output logic [PC_W-1:0]  pc_plus4_out,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int PW = INS_W + PC_W;

   logic          held_vld;
   logic [PW-1:0] held_dat;
   logic [PW-1:0] in_dat;

   assign in_dat = {ins_in, pc_plus4_in};

   if (SKID) begin : g_skid
      pipe_skid_buf #(
         .W (PW)
      ) u_skid (
         .clk       (clk),
         .reset     (reset),
         .flush     (flush),
         .in_valid  (in_valid),
         .in_ready  (in_ready),
         .in_data   (in_dat),
         .out_valid (held_vld),
         .out_ready (out_ready),
         .out_data  (held_dat)
      );
   end else begin : g_single
      logic          vld_q, vld_d;
      logic [PW-1:0] dat_q, dat_d;
      logic          accept;
      logic          drain;

      assign in_ready = !vld_q || out_ready;
      assign accept   = in_valid && in_ready;
      assign drain    = vld_q && out_ready;
      assign held_vld = vld_q;
      assign held_dat = dat_q;

      // Load on accept, otherwise empty on drain; flush wins over a same-cycle accept.
      always_comb begin
         vld_d = vld_q;
         dat_d = dat_q;
         if (flush) begin
            vld_d = 1'b0;
         end else if (accept) begin
            vld_d = 1'b1;
            dat_d = in_dat;
         end else if (drain) begin
            vld_d = 1'b0;
         end
      end

      // Single holding register.
      always_ff @(posedge clk) begin
         if (reset) begin
            vld_q <= 1'b0;
            dat_q <= '0;
         end else begin
            vld_q <= vld_d;
            dat_q <= dat_d;
         end
      end
   end

   assign out_valid    = held_vld;
   assign ins_out      = held_vld ? held_dat[PW-1:PC_W] : NOP_INS;
   assign pc_plus4_out = held_vld ? held_dat[PC_W-1:0]  : '0;

   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

   assign stall_cnt = stall_cnt_q;

   // Count stalled cycles, sticking at all-ones; flush deliberately leaves it alone.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (held_vld && !out_ready && (stall_cnt_q != {CNT_W{1'b1}})) begin
         stall_cnt_d = stall_cnt_q + CNT_W'(1);
      end
   end

   // Stall counter register, cleared only by reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
      end
   end

endmodule
